pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter CTRL_W, default 12: width of the control field (RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl).
REQ-002 Parameter DATA_W, default 175: width of the data field (Rs1, Rs2, Rd, RD1, RD2, PC, ImmExt, PCPlus4).
REQ-003 Parameter CNT_W, default 16: width of each performance counter.
REQ-004 Port CLK, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 Port CLR, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port in_valid, input, 1 bit: the upstream stage presents an entry.
REQ-007 Port in_ready, output, 1 bit: the stage can accept an entry this cycle.
REQ-008 Port in_ctrl, input, CTRL_W bits: upstream control field.
REQ-009 Port in_data, input, DATA_W bits: upstream data field.
REQ-010 Port flush, input, 1 bit: synchronous kill of all held and incoming entries.
REQ-011 Port out_valid, output, 1 bit: the output entry is valid.
REQ-012 Port out_ready, input, 1 bit: the downstream stage accepts the output entry.
REQ-013 Port out_ctrl, output, CTRL_W bits: registered control field.
REQ-014 Port out_data, output, DATA_W bits: registered data field.
REQ-015 Port stall_cnt, output, CNT_W bits: count of stall cycles.
REQ-016 Port bubble_cnt, output, CNT_W bits: count of bubble cycles.

Function
REQ-017 The stage SHALL hold two entries: main (drives the outputs) and skid; each has its own valid bit.
REQ-018 in_ready SHALL equal NOT skid_valid, driven directly from a register with no combinational path from out_ready.
REQ-019 An input transfer SHALL occur when in_valid=1 and in_ready=1; an output transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-020 When main is empty, or main is consumed this cycle with the skid empty, an accepted input SHALL load into main, giving one-cycle latency.
REQ-021 When main is held (out_valid=1 and out_ready=0), an accepted input SHALL load into the skid entry, and in_ready SHALL be 0 on the next cycle.
REQ-022 When main is consumed and the skid is valid, the skid SHALL move to main in the same edge, and in_ready SHALL return to 1 on the next cycle.
REQ-023 When main is consumed and the skid is valid, any new input SHALL NOT be accepted that cycle, because in_ready=0.
REQ-024 Entries SHALL leave in arrival order; no entry SHALL be lost or duplicated.
REQ-025 While out_valid=1 and out_ready=0, out_ctrl and out_data SHALL remain stable.
REQ-026 While out_valid=0, out_ctrl SHALL be all zeros; this bubble carries no architectural side effects.
REQ-027 While out_valid=0, out_data holds its last value.
REQ-028 On a flush edge, main_valid and skid_valid SHALL clear.
REQ-029 On a flush edge, out_ctrl SHALL clear to zero.
REQ-030 On a flush edge, any input presented that cycle SHALL be discarded.
REQ-031 flush SHALL have priority over every transfer.
REQ-032 in_ready SHALL be 1 on the cycle after a flush.
REQ-033 stall_cnt SHALL increment on each cycle where out_valid=1, out_ready=0 and flush=0.
REQ-034 bubble_cnt SHALL increment on each cycle where out_valid=0 and flush=0.
REQ-035 Both counters SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.

Reset
REQ-036 CLR=1 SHALL immediately force main_valid, skid_valid, out_ctrl, out_data, stall_cnt and bubble_cnt to zero.
REQ-037 While CLR=1, in_ready SHALL read 1.
REQ-038 Asserting CLR mid-operation SHALL drop all held entries without producing an output transfer.
REQ-039 The first accepted input after CLR deasserts SHALL appear at the outputs one edge later.

Verification
REQ-040 Streaming: out_ready=1 and in_valid=1 for 10 cycles with data 1..10 -> outputs 1..10, each one cycle after input, in_ready=1 throughout.
REQ-041 Backpressure: out_ready=0 while A then B are accepted -> in_ready=0 after B; then set out_ready=1 -> A out, B out, in_ready=1 on the cycle B moves to main.
REQ-042 Flush with both entries full, and C presented in the flush cycle -> next cycle out_valid=0, out_ctrl=0, in_ready=1; C never appears.
REQ-043 Counters with CNT_W=4: hold a valid output with out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); idle input for 3 cycles -> bubble_cnt=3.
REQ-044 Reset mid-stream: assert CLR asynchronously between edges while both entries are valid -> out_valid=0, counters=0, in_ready=1 immediately, without waiting for an edge.
REQ-045 Random in_valid, out_ready and flush over 10,000 cycles against a reference FIFO model -> order preserved, no loss or duplication except flushed entries.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Pipeline register stage with a one-entry skid buffer. The
//            upstream ready is taken straight from a register, so out_ready
//            never reaches in_ready combinationally. The output control field
//            is zeroed whenever the stage holds no valid entry, and a pair of
//            saturating counters records stall and bubble cycles.
// Ports    : CLK, CLR              clock / async active-high reset
//            in_valid, in_ready    upstream handshake
//            in_ctrl, in_data      upstream control / data fields
//            flush                 synchronous kill of held and incoming entries
//            out_valid, out_ready  downstream handshake
//            out_ctrl, out_data    registered control / data fields
//            stall_cnt, bubble_cnt saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 175,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic              r_main_valid;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_free;

  // The skid can only fill while main is held, so skid_valid implies
  // main_valid and a free skid is the only condition for accepting input.
  assign in_ready    = ~r_skid_valid;
  assign w_in_fire   = in_valid & ~r_skid_valid;
  assign w_out_fire  = r_main_valid & out_ready;
  assign w_main_free = ~r_main_valid | w_out_fire;

  assign out_valid  = r_main_valid;
  assign out_ctrl   = r_main_ctrl;
  assign out_data   = r_main_data;
  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_ctrl  <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      // Data is left in place; only the valid bits and the control field,
      // which carries the side effects, are killed.
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Older skid entry goes first; input is blocked this cycle.
        r_main_valid <= 1'b1;
        r_main_ctrl  <= r_skid_ctrl;
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= in_ctrl;
        r_main_data  <= in_data;
      end else begin
        // Bubble: clear control, keep the last data value.
        r_main_valid <= 1'b0;
        r_main_ctrl  <= '0;
      end
    end else if (w_in_fire) begin
      // Main is held by downstream backpressure; park the input.
      r_skid_valid <= 1'b1;
      r_skid_ctrl  <= in_ctrl;
      r_skid_data  <= in_data;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!flush) begin
      if (r_main_valid && !out_ready && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (!r_main_valid && (r_bubble_cnt != C_CNT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. A reference queue of up
//            to two entries predicts in_ready, out_valid, out_ctrl, out_data
//            and both counters every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int CTRL_W = 12;
  localparam int DATA_W = 175;
  localparam int CNT_W  = 4;
  localparam int C_MAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              CLK = 1'b0;
  logic              CLR;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  ent_t              q[$];
  logic [DATA_W-1:0] m_data;
  int                m_stall;
  int                m_bubble;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data   = '0;
    m_stall  = 0;
    m_bubble = 0;
  endtask

  task automatic check_all();
    chk("in_ready",   DATA_W'(in_ready),   DATA_W'(q.size() < 2));
    chk("out_valid",  DATA_W'(out_valid),  DATA_W'(q.size() > 0));
    chk("out_ctrl",   DATA_W'(out_ctrl),   (q.size() > 0) ? DATA_W'(q[0].c) : '0);
    chk("out_data",   out_data,            m_data);
    chk("stall_cnt",  DATA_W'(stall_cnt),  DATA_W'(m_stall));
    chk("bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_bubble));
  endtask

  // Drive one cycle of inputs, check the current outputs, advance the model
  // across the coming rising edge, and return 1 time unit after that edge.
  task automatic cyc(input logic iv, input logic [CTRL_W-1:0] c,
                     input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    bit   ofire;
    bit   ifire;
    ent_t e;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    if (fl) begin
      q.delete();
    end else begin
      ofire = (q.size() > 0) && ordy;
      ifire = iv && (q.size() < 2);
      if ((q.size() > 0) && !ordy && (m_stall < C_MAX)) m_stall++;
      if ((q.size() == 0) && (m_bubble < C_MAX)) m_bubble++;
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        e.c = c;
        e.d = d;
        q.push_back(e);
      end
    end
    if (q.size() > 0) m_data = q[0].d;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = 1'($urandom_range(1, 0));
    return r;
  endfunction

  initial begin
    CLR = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #2;
    check_all();                     // reset state, in_ready=1 while CLR
    @(posedge CLK);
    #3 CLR = 1'b0;

    // Streaming 1..10, one-cycle latency
    for (int i = 1; i <= 10; i++) cyc(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: A to main, B to skid, then drain
    cyc(1'b1, 12'hA0A, DATA_W'('hAAAA), 1'b0, 1'b0);
    cyc(1'b1, 12'hB0B, DATA_W'('hBBBB), 1'b0, 1'b0);
    cyc(1'b1, 12'hEEE, DATA_W'('hEEEE), 1'b0, 1'b0);   // refused, in_ready=0
    cyc(1'b1, 12'hEEF, DATA_W'('hEEEF), 1'b1, 1'b0);   // A out, B moves, still refused
    cyc(1'b0, '0, '0, 1'b1, 1'b0);                     // B out
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with both entries full and C presented
    cyc(1'b1, 12'h111, DATA_W'('h1111), 1'b0, 1'b0);
    cyc(1'b1, 12'h222, DATA_W'('h2222), 1'b0, 1'b0);
    cyc(1'b1, 12'hCCC, DATA_W'('hCCCC), 1'b0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);
    // Flush with only main full, so the presented entry would be accepted
    cyc(1'b1, 12'h333, DATA_W'('h3333), 1'b0, 1'b0);
    cyc(1'b1, 12'hCC2, DATA_W'('hCC22), 1'b1, 1'b1);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Counters: fresh reset, 3 idle cycles, then 20 stall cycles
    CLR = 1'b1; #1; model_reset(); check_all(); CLR = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 1'b0);
    check_all();
    cyc(1'b1, 12'h5A5, DATA_W'('h5A5A), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, '0, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream with both entries valid
    cyc(1'b1, 12'h777, DATA_W'('h7777), 1'b0, 1'b0);
    cyc(1'b1, 12'h888, DATA_W'('h8888), 1'b0, 1'b0);
    #2 CLR = 1'b1;
    #1;
    model_reset();
    check_all();                     // before any clock edge
    #1 CLR = 1'b0;
    cyc(1'b1, 12'h999, DATA_W'('h9999), 1'b1, 1'b0);   // appears one edge later
    cyc(1'b0, '0, '0, 1'b1, 1'b0);

    // Random traffic against the reference queue
    for (int i = 0; i < 10000; i++) begin
      cyc(1'($urandom_range(1, 0)), CTRL_W'($urandom()), rnd_data(),
          ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
